// File: rtl/regs_wb_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// regs_wb_ctrl_pkg
//   Shared definitions for the writeback controller: default data/address
//   widths, register count and the requester identifiers used by the
//   round-robin arbiter.
// ---------------------------------------------------------------------------
package regs_wb_ctrl_pkg;

  localparam int XLEN     = 32;
  localparam int AW       = 5;
  localparam int NUM_REGS = 1 << AW;

  // Identifies which writeback source was granted most recently.
  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

endpackage : regs_wb_ctrl_pkg

// File: rtl/regs_wb_ctrl_arb.sv
// ---------------------------------------------------------------------------
// wb_rr_arb
//   Two-way round-robin arbiter for the writeback port.
//
//   Ports
//     clk      in   clock, rising edge
//     rst_n    in   asynchronous active-low reset
//     a_req_i  in   requester A (ALU) has a valid writeback
//     b_req_i  in   requester B (LSU) has a valid writeback
//     a_gnt_o  out  combinational grant to A
//     b_gnt_o  out  combinational grant to B
//
//   A lone requester is granted immediately. Under contention the requester
//   that did not win the previous transfer is granted, so the loser waits at
//   most one cycle. Because a grant is only ever given to a valid requester,
//   every grant is a transfer and the pointer moves on every grant.
// ---------------------------------------------------------------------------
module wb_rr_arb (
  input  logic clk,
  input  logic rst_n,
  input  logic a_req_i,
  input  logic b_req_i,
  output logic a_gnt_o,
  output logic b_gnt_o
);

  import regs_wb_ctrl_pkg::*;

  req_id_e last_q;
  req_id_e last_d;
  logic    a_win;
  logic    b_win;

  always_comb begin
    a_win = 1'b0;
    b_win = 1'b0;
    if (a_req_i && b_req_i) begin
      // Contention: the side that lost last time goes now.
      if (last_q == REQ_B) a_win = 1'b1;
      else                 b_win = 1'b1;
    end else if (a_req_i) begin
      a_win = 1'b1;
    end else if (b_req_i) begin
      b_win = 1'b1;
    end
  end

  // Grants are held low while reset is asserted so nothing can hand off
  // into a controller that is being cleared.
  assign a_gnt_o = a_win && rst_n;
  assign b_gnt_o = b_win && rst_n;

  always_comb begin
    last_d = last_q;
    if (a_gnt_o)      last_d = REQ_A;
    else if (b_gnt_o) last_d = REQ_B;
  end

  // Reset to "B last" so A takes the first contended slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= REQ_B;
    else        last_q <= last_d;
  end

endmodule : wb_rr_arb

// File: rtl/regs_wb_ctrl.sv
// ---------------------------------------------------------------------------
// regs_wb_ctrl
//   Writeback controller for a register file with a single write port.
//   Arbitrates two writeback sources (ALU = A, LSU = B) onto the write port
//   with one cycle of latency, and keeps a pending-write scoreboard that the
//   issue stage sets (claim) and writebacks clear.
//
//   Ports
//     clk, rst_n                          clock / async active-low reset
//     a_valid, a_ready, a_addr, a_data    requester A writeback handshake
//     b_valid, b_ready, b_addr, b_data    requester B writeback handshake
//     claim_valid, claim_ready, claim_addr  destination reservation
//     rs1_addr, rs2_addr                  scoreboard query addresses
//     rs1_busy, rs2_busy                  query results (combinational)
//     w_en, waddr, wdata                  registered register-file write port
//     busy                                full scoreboard vector
//
//   x0 is hardwired: writes to it complete the handshake but never reach the
//   write port, and it can never be marked busy.
// ---------------------------------------------------------------------------
module regs_wb_ctrl #(
  parameter int XLEN = regs_wb_ctrl_pkg::XLEN,
  parameter int AW   = regs_wb_ctrl_pkg::AW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // requester A (ALU)
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [AW-1:0]        a_addr,
  input  logic [XLEN-1:0]      a_data,
  // requester B (load/store unit)
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [AW-1:0]        b_addr,
  input  logic [XLEN-1:0]      b_data,
  // issue-stage destination claim
  input  logic                 claim_valid,
  output logic                 claim_ready,
  input  logic [AW-1:0]        claim_addr,
  // source operand queries
  input  logic [AW-1:0]        rs1_addr,
  input  logic [AW-1:0]        rs2_addr,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  // register-file write port
  output logic                 w_en,
  output logic [AW-1:0]        waddr,
  output logic [XLEN-1:0]      wdata,
  // scoreboard
  output logic [(1<<AW)-1:0]   busy
);

  import regs_wb_ctrl_pkg::*;

  localparam int NREGS = 1 << AW;

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  logic a_gnt;
  logic b_gnt;

  wb_rr_arb u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_req_i (a_valid),
    .b_req_i (b_valid),
    .a_gnt_o (a_gnt),
    .b_gnt_o (b_gnt)
  );

  assign a_ready = a_gnt;
  assign b_ready = b_gnt;

  logic            xfer;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            wr_fire;

  // The arbiter grants at most one side, and only a valid one.
  assign xfer    = (a_valid && a_ready) || (b_valid && b_ready);
  assign wb_addr = b_gnt ? b_addr : a_addr;
  assign wb_data = b_gnt ? b_data : a_data;
  assign wr_fire = xfer && (wb_addr != '0);

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             claim_fire;

  // busy_q[0] is always 0, so a claim of x0 is always ready.
  assign claim_ready = !busy_q[claim_addr];
  assign claim_fire  = claim_valid && claim_ready && (claim_addr != '0);

  always_comb begin
    busy_d = busy_q;
    if (wr_fire)    busy_d[wb_addr]    = 1'b0;
    // Applied after the clear: a new reservation beats a retiring write to
    // the same register, since the new producer is still outstanding.
    if (claim_fire) busy_d[claim_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy = busy_q;

  // Queries see the registered state only; a clear lands one edge later.
  assign rs1_busy = busy_q[rs1_addr];
  assign rs2_busy = busy_q[rs2_addr];

  // ---------------------------------------------------------------------
  // Write port registers
  // ---------------------------------------------------------------------
  logic            w_en_q;
  logic            w_en_d;
  logic [AW-1:0]   waddr_q;
  logic [AW-1:0]   waddr_d;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] wdata_d;

  // Address/data hold between writes; x0 transfers leave them untouched.
  always_comb begin
    w_en_d  = wr_fire;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (wr_fire) begin
      waddr_d = wb_addr;
      wdata_d = wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_en_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      w_en_q  <= w_en_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign w_en  = w_en_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

endmodule : regs_wb_ctrl

// File: tb/tb_regs_wb_ctrl.sv
module tb_regs_wb_ctrl;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            a_valid, a_ready;
  logic [AW-1:0]   a_addr;
  logic [XLEN-1:0] a_data;
  logic            b_valid, b_ready;
  logic [AW-1:0]   b_addr;
  logic [XLEN-1:0] b_data;
  logic            claim_valid, claim_ready;
  logic [AW-1:0]   claim_addr;
  logic [AW-1:0]   rs1_addr, rs2_addr;
  logic            rs1_busy, rs2_busy;
  logic            w_en;
  logic [AW-1:0]   waddr;
  logic [XLEN-1:0] wdata;
  logic [31:0]     busy;

  regs_wb_ctrl #(.XLEN(XLEN), .AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_valid     (a_valid),
    .a_ready     (a_ready),
    .a_addr      (a_addr),
    .a_data      (a_data),
    .b_valid     (b_valid),
    .b_ready     (b_ready),
    .b_addr      (b_addr),
    .b_data      (b_data),
    .claim_valid (claim_valid),
    .claim_ready (claim_ready),
    .claim_addr  (claim_addr),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .w_en        (w_en),
    .waddr       (waddr),
    .wdata       (wdata),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_mis = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_wr(input logic [AW-1:0] addr, input logic [XLEN-1:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write the DUT presents must match the oldest expected one.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && w_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL unexpected_write: got waddr=%0d wdata=%0d, no write expected at %0t",
                   waddr, wdata, $time);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 64'(waddr), 64'(e.addr));
          chk("wr_data", 64'(wdata), 64'(e.data));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    claim_valid = 1'b0; claim_addr = '0;
    rs1_addr = 5'd5; rs2_addr = 5'd6;

    // Readies forced low during reset even with requests present.
    #1;
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    chk("rst_a_ready", 64'(a_ready), 64'd0);
    chk("rst_b_ready", 64'(b_ready), 64'd0);
    chk("rst_w_en",    64'(w_en),    64'd0);
    chk("rst_busy",    64'(busy),    64'd0);
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (2) @(posedge clk);
    cyc();
    rst_n = 1'b1;

    // Idle after reset.
    repeat (3) cyc();
    chk("idle_w_en",     64'(w_en),     64'd0);
    chk("idle_busy",     64'(busy),     64'd0);
    chk("idle_rs1_busy", 64'(rs1_busy), 64'd0);
    chk("idle_rs2_busy", 64'(rs2_busy), 64'd0);

    // Continuous contention: A first after reset, then alternating.
    for (int i = 0; i < 4; i++) begin
      cyc();
      a_valid = 1'b1; a_addr = 5'd1; a_data = 32'd1;
      b_valid = 1'b1; b_addr = 5'd2; b_data = 32'd2;
      #1;
      chk("rr_a_ready", 64'(a_ready), (i % 2 == 0) ? 64'd1 : 64'd0);
      chk("rr_b_ready", 64'(b_ready), (i % 2 == 0) ? 64'd0 : 64'd1);
      if (i % 2 == 0) push_wr(5'd1, 32'd1);
      else            push_wr(5'd2, 32'd2);
    end
    cyc();
    a_valid = 1'b0; b_valid = 1'b0;

    // Claim x5, query it, then retire it through A.
    cyc();
    claim_valid = 1'b1; claim_addr = 5'd5;
    #1;
    chk("claim5_ready", 64'(claim_ready), 64'd1);
    cyc();
    claim_valid = 1'b0;
    rs1_addr = 5'd5;
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'd1000;
    #1;
    chk("rs1_busy_5", 64'(rs1_busy), 64'd1);
    chk("busy_5_set", 64'(busy), 64'h20);
    chk("a_ready_5",  64'(a_ready), 64'd1);
    push_wr(5'd5, 32'd1000);
    cyc();
    a_valid = 1'b0;
    #1;
    chk("w_en_5",       64'(w_en), 64'd1);
    chk("busy_5_clear", 64'(busy), 64'd0);
    chk("rs1_busy_5c",  64'(rs1_busy), 64'd0);

    // x0 transfer and x0 claim.
    cyc();
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'd2000;
    #1;
    chk("a_ready_x0", 64'(a_ready), 64'd1);
    cyc();
    a_valid = 1'b0;
    claim_valid = 1'b1; claim_addr = 5'd0;
    #1;
    chk("w_en_x0",        64'(w_en), 64'd0);
    chk("claim_x0_ready", 64'(claim_ready), 64'd1);
    cyc();
    claim_valid = 1'b0;
    #1;
    chk("busy_after_x0", 64'(busy), 64'd0);

    // WAW stall on x7, clear via B, then reclaim.
    cyc();
    claim_valid = 1'b1; claim_addr = 5'd7;
    #1;
    chk("claim7_ready", 64'(claim_ready), 64'd1);
    cyc();
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'd77;
    #1;
    chk("claim7_stall", 64'(claim_ready), 64'd0);
    chk("busy_7_set",   64'(busy), 64'h80);
    chk("b_ready_7",    64'(b_ready), 64'd1);
    push_wr(5'd7, 32'd77);
    cyc();
    b_valid = 1'b0;
    #1;
    chk("busy_7_clear",  64'(busy), 64'd0);
    chk("claim7_reopen", 64'(claim_ready), 64'd1);
    cyc();
    claim_valid = 1'b0;
    #1;
    chk("busy_7_reset", 64'(busy), 64'h80);

    // Same-cycle claim and write to non-busy x9: set wins.
    cyc();
    claim_valid = 1'b1; claim_addr = 5'd9;
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'd99;
    #1;
    chk("claim9_ready", 64'(claim_ready), 64'd1);
    chk("a_ready_9",    64'(a_ready), 64'd1);
    push_wr(5'd9, 32'd99);
    cyc();
    claim_valid = 1'b0; a_valid = 1'b0;
    #1;
    chk("busy_set_wins", 64'(busy), 64'h280);

    // Write to x31 registered, then reset before it can be seen.
    cyc();
    a_valid = 1'b1; a_addr = 5'd31; a_data = 32'd3000;
    #1;
    chk("a_ready_31", 64'(a_ready), 64'd1);
    cyc();
    chk("w_en_31_pre", 64'(w_en), 64'd1);
    rst_n = 1'b0; a_valid = 1'b0;
    #1;
    chk("async_w_en",  64'(w_en),  64'd0);
    chk("async_waddr", 64'(waddr), 64'd0);
    chk("async_wdata", 64'(wdata), 64'd0);
    chk("async_busy",  64'(busy),  64'd0);
    repeat (2) @(posedge clk);
    cyc();
    rst_n = 1'b1;
    repeat (3) begin
      cyc();
      chk("post_rst_w_en", 64'(w_en), 64'd0);
    end

    // Pointer back to "B last": A wins the first contention.
    cyc();
    a_valid = 1'b1; a_addr = 5'd1; a_data = 32'd1;
    b_valid = 1'b1; b_addr = 5'd2; b_data = 32'd2;
    #1;
    chk("post_rst_a_ready", 64'(a_ready), 64'd1);
    chk("post_rst_b_ready", 64'(b_ready), 64'd0);
    push_wr(5'd1, 32'd1);
    cyc();
    a_valid = 1'b0;
    #1;
    chk("post_rst_b_alone", 64'(b_ready), 64'd1);
    push_wr(5'd2, 32'd2);
    cyc();
    b_valid = 1'b0;

    repeat (3) cyc();
    chk("pending_writes", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_regs_wb_ctrl

// File: doc/regs_wb_ctrl.md
REGS_WB_CTRL -- requirements
Module: regs_wb_ctrl

Interface
REQ-001 Parameter: XLEN, 32, data width of register file and write sources.
REQ-002 Parameter: AW, 5, register address width (32 registers, x0..x31).
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  in  1  asynchronous active-low reset.
REQ-005 Port: a_valid/a_ready/a_addr/a_data  in/out/in/in  1/1/AW/XLEN  requester A (ALU) writeback.
REQ-006 Port: b_valid/b_ready/b_addr/b_data  in/out/in/in  1/1/AW/XLEN  requester B (load/store unit) writeback.
REQ-007 Port: claim_valid/claim_ready/claim_addr  in/out/in  1/1/AW  issue stage reserves a destination register.
REQ-008 Port: rs1_addr, rs2_addr  in  AW each  scoreboard query addresses.
REQ-009 Port: rs1_busy, rs2_busy  out  1 each  source register has a pending write.
REQ-010 Port: w_en/waddr/wdata  out  1/AW/XLEN  single write port driving the register file.
REQ-011 Port: busy  out  32  scoreboard vector, bit i = xi pending.

Function
REQ-012 Transfer on requester X occurs in a cycle with X_valid && X_ready high; requester holds valid/addr/data stable until transfer.
REQ-013 a_ready/b_ready combinational grant: only one valid -> that one granted; none valid -> both low.
REQ-014 Both valid -> round-robin: grant the requester not granted at the last transfer; last-grant pointer updates only on a transfer.
REQ-015 At most one transfer per cycle; the ungranted requester waits at most one cycle under continuous contention.
REQ-016 Write latency 1: transfer in cycle n -> w_en=1, waddr/wdata = granted addr/data in cycle n+1; no transfer -> w_en=0, waddr/wdata hold last value.
REQ-017 Transfer with addr 0 completes handshake but produces w_en=0 (x0 never written).
REQ-018 claim_ready = !busy[claim_addr] (WAW stall); claim_addr 0 -> claim_ready=1, no bit set.
REQ-019 Claim accepted (claim_valid && claim_ready) sets busy[claim_addr] at next edge.
REQ-020 Transfer with addr k != 0 clears busy[k] at next edge (same edge w_en asserts).
REQ-021 Accepted claim and clearing transfer to same address in one cycle -> set wins, busy stays 1.
REQ-022 rsN_busy = busy[rsN_addr] combinational; rsN_addr 0 -> 0; no bypass of the clearing edge.
REQ-023 Transfer to a non-busy register is legal; it writes and leaves busy[k]=0.
REQ-024 busy[0] is constant 0.

Reset
REQ-025 rst_n low asynchronously forces w_en=0, waddr=0, wdata=0, busy=0, pointer to "B last" (A wins first contention).
REQ-026 Reset asserted mid-operation discards any registered write; no w_en pulse after rst_n rises until a new transfer.
REQ-027 a_ready/b_ready follow REQ-013 from inputs; during reset they are forced 0.

Structure
REQ-028 Shared package holds XLEN, AW, NUM_REGS=32, and requester-id enum (REQ_A, REQ_B).
REQ-029 Round-robin grant logic and pointer shall live in sub-module wb_rr_arb; scoreboard and output registers stay in regs_wb_ctrl.
REQ-030 Outputs w_en/waddr/wdata are driven directly from flops.

Verification
REQ-031 Reset, then idle 3 cycles -> w_en=0, busy=0, rs1_busy=rs2_busy=0.
REQ-032 claim x5; next cycle rs1_addr=5 -> rs1_busy=1; a_valid, a_addr=5, a_data=1000 -> a_ready=1, next cycle w_en=1, waddr=5, wdata=1000, busy[5]=0.
REQ-033 a and b valid every cycle (a_addr=1/a_data=1, b_addr=2/b_data=2) for 4 cycles -> waddr sequence 1,2,1,2; each ready pulses alternately.
REQ-034 busy[7]=1, claim_addr=7 -> claim_ready=0; same cycle b transfer to 7 plus claim_valid of 7 after clear -> busy[7] ends 1 (set wins).
REQ-035 a transfer with a_addr=0, a_data=2000 -> a_ready=1, w_en stays 0; claim x0 -> busy unchanged.
REQ-036 a transfer to x31 (data 3000), assert rst_n=0 before next edge -> w_en=0 immediately, no write after release.
